rf_write_ctrl: RTL and testbench

Write-side controller for the 32×64-bit register file: collects writeback results from the MEM/WB stage, up to two destination writes per instruction, and serializes them onto the register file's single write port (`RegWrite`/`WriteReg`/`WriteData`). It buffers pending writes in a small in-order queue and suppresses writes to XZR (X31). It also exposes a forwarding lookup so decode can see values that are queued but not yet written. It sits between the WB pipeline register and the register file.

---
 rtl/rf_pkg.sv | 12 +
 rtl/rf_wq_mem.sv | 57 +++++
 rtl/rf_write_ctrl.sv | 93 +++++++++
 tb/tb_rf_write_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared register-file write-side types and constants.
package rf_pkg;
    localparam int XLEN = 64;
    localparam int AW   = 5;

    localparam logic [AW-1:0] XZR_IDX = 5'd31;

    typedef struct packed {
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } rf_wr_t;
endpackage

// File: rtl/rf_wq_mem.sv
// In-order write queue: dual enqueue, single pop, exposes storage
// so the controller can search it for forwarding.
module rf_wq_mem
    import rf_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_enq0,
    input  logic          i_enq1,
    input  rf_wr_t        i_wr0,
    input  rf_wr_t        i_wr1,
    input  logic          i_pop,
    output rf_wr_t        o_head,
    output logic [PW-1:0] o_rd_ptr,
    output logic [CW-1:0] o_count,
    output rf_wr_t        o_mem [DEPTH]
);
    rf_wr_t        r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    logic [1:0]    w_n_enq;
    logic [PW-1:0] w_slot1;
    logic          w_pop;

    assign w_n_enq = {1'b0, i_enq0} + {1'b0, i_enq1};
    // Slot 1 lands right behind slot 0 only when slot 0 is kept.
    assign w_slot1 = r_wr_ptr + PW'(i_enq0);
    assign w_pop   = i_pop & (r_count != '0);

    always_ff @(posedge clk) begin
        if (i_enq0) r_mem[r_wr_ptr] <= i_wr0;
        if (i_enq1) r_mem[w_slot1]  <= i_wr1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + PW'(w_n_enq);
            r_rd_ptr <= r_rd_ptr + PW'(w_pop);
            r_count  <= r_count + CW'(w_n_enq) - CW'(w_pop);
        end
    end

    assign o_head   = r_mem[r_rd_ptr];
    assign o_rd_ptr = r_rd_ptr;
    assign o_count  = r_count;
    assign o_mem    = r_mem;
endmodule

// File: rtl/rf_write_ctrl.sv
// Serializes up to two WB writes per instruction onto the single
// register-file write port, dropping XZR and forwarding queued data.
module rf_write_ctrl #(
    parameter  int XLEN  = 64,
    parameter  int AW    = 5,
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic            clk,
    input  logic            Reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_we0,
    input  logic [AW-1:0]   in_rd0,
    input  logic [XLEN-1:0] in_data0,
    input  logic            in_we1,
    input  logic [AW-1:0]   in_rd1,
    input  logic [XLEN-1:0] in_data1,
    output logic            RegWrite,
    output logic [AW-1:0]   WriteReg,
    output logic [XLEN-1:0] WriteData,
    input  logic [AW-1:0]   chk_reg1,
    input  logic [AW-1:0]   chk_reg2,
    output logic            fwd_hit1,
    output logic            fwd_hit2,
    output logic [XLEN-1:0] fwd_data1,
    output logic [XLEN-1:0] fwd_data2,
    output logic [CW-1:0]   count
);
    import rf_pkg::*;

    rf_wr_t        w_wr0;
    rf_wr_t        w_wr1;
    rf_wr_t        w_head;
    rf_wr_t        w_mem [DEPTH];
    logic [PW-1:0] w_rd_ptr;
    logic [CW-1:0] w_count;
    logic          w_acc;
    logic          w_enq0;
    logic          w_enq1;
    logic          w_nempty;
    logic [PW-1:0] w_idx;

    assign w_wr0    = '{rd: in_rd0, data: in_data0};
    assign w_wr1    = '{rd: in_rd1, data: in_data1};
    assign w_nempty = (w_count != '0);
    assign in_ready = (CW'(DEPTH) - w_count) >= CW'(2);
    assign w_acc    = in_valid & in_ready;
    assign w_enq0   = w_acc & in_we0 & (in_rd0 != XZR_IDX);
    assign w_enq1   = w_acc & in_we1 & (in_rd1 != XZR_IDX);

    rf_wq_mem #(.DEPTH(DEPTH)) u_wq (
        .clk      (clk),
        .rst_n    (Reset),
        .i_enq0   (w_enq0),
        .i_enq1   (w_enq1),
        .i_wr0    (w_wr0),
        .i_wr1    (w_wr1),
        .i_pop    (w_nempty),
        .o_head   (w_head),
        .o_rd_ptr (w_rd_ptr),
        .o_count  (w_count),
        .o_mem    (w_mem)
    );

    assign RegWrite  = w_nempty;
    assign WriteReg  = w_nempty ? w_head.rd : '0;
    assign WriteData = w_nempty ? w_head.data : '0;
    assign count     = w_count;

    // Walk oldest to youngest so the last match wins.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_hit2  = 1'b0;
        fwd_data1 = '0;
        fwd_data2 = '0;
        w_idx     = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = w_rd_ptr + PW'(k);
            if (CW'(k) < w_count) begin
                if (chk_reg1 != XZR_IDX && w_mem[w_idx].rd == chk_reg1) begin
                    fwd_hit1  = 1'b1;
                    fwd_data1 = w_mem[w_idx].data;
                end
                if (chk_reg2 != XZR_IDX && w_mem[w_idx].rd == chk_reg2) begin
                    fwd_hit2  = 1'b1;
                    fwd_data2 = w_mem[w_idx].data;
                end
            end
        end
    end
endmodule

// File: tb/tb_rf_write_ctrl.sv
// Bench for rf_write_ctrl: directed cases plus random traffic
// checked against a queue-based model of the write port.
module tb_rf_write_ctrl;
    logic        clk = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_we0;
    logic [4:0]  in_rd0;
    logic [63:0] in_data0;
    logic        in_we1;
    logic [4:0]  in_rd1;
    logic [63:0] in_data1;
    logic        RegWrite;
    logic [4:0]  WriteReg;
    logic [63:0] WriteData;
    logic [4:0]  chk_reg1;
    logic [4:0]  chk_reg2;
    logic        fwd_hit1;
    logic        fwd_hit2;
    logic [63:0] fwd_data1;
    logic [63:0] fwd_data2;
    logic [2:0]  count;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] d;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    rf_write_ctrl dut (
        .clk       (clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_we0    (in_we0),
        .in_rd0    (in_rd0),
        .in_data0  (in_data0),
        .in_we1    (in_we1),
        .in_rd1    (in_rd1),
        .in_data1  (in_data1),
        .RegWrite  (RegWrite),
        .WriteReg  (WriteReg),
        .WriteData (WriteData),
        .chk_reg1  (chk_reg1),
        .chk_reg2  (chk_reg2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, obs, exp, $time);
        end
    endtask

    function automatic void model_fwd(input logic [4:0] c,
                                      output logic h,
                                      output logic [63:0] d);
        h = 1'b0;
        d = '0;
        if (c != 5'd31)
            foreach (q[i])
                if (q[i].rd == c) begin
                    h = 1'b1;
                    d = q[i].d;
                end
    endfunction

    task automatic check_outputs();
        logic        h;
        logic [63:0] d;
        int          n;
        n = q.size();
        check("regwrite", RegWrite, n != 0);
        check("writereg", WriteReg, n != 0 ? q[0].rd : 5'd0);
        check("writedata", WriteData, n != 0 ? q[0].d : 64'd0);
        check("count", count, n);
        check("in_ready", in_ready, (4 - n) >= 2);
        model_fwd(chk_reg1, h, d);
        check("fwd_hit1", fwd_hit1, h);
        check("fwd_data1", fwd_data1, d);
        model_fwd(chk_reg2, h, d);
        check("fwd_hit2", fwd_hit2, h);
        check("fwd_data2", fwd_data2, d);
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic step(input logic v, input logic w0, input logic [4:0] r0,
                        input logic [63:0] d0, input logic w1,
                        input logic [4:0] r1, input logic [63:0] d1,
                        input logic [4:0] c1, input logic [4:0] c2);
        bit rdy;
        chk_reg1 = c1;
        chk_reg2 = c2;
        #1;
        check_outputs();
        in_valid = v;
        in_we0   = w0;
        in_rd0   = r0;
        in_data0 = d0;
        in_we1   = w1;
        in_rd1   = r1;
        in_data1 = d1;
        @(posedge clk);
        rdy = (4 - q.size()) >= 2;
        if (q.size() > 0) void'(q.pop_front());
        if (v && rdy) begin
            if (w0 && r0 != 5'd31) q.push_back('{rd: r0, d: d0});
            if (w1 && r1 != 5'd31) q.push_back('{rd: r1, d: d1});
        end
        @(negedge clk);
    endtask

    task automatic idle(input logic [4:0] c1, input logic [4:0] c2);
        step(0, 0, 0, 0, 0, 0, 0, c1, c2);
    endtask

    function automatic logic [4:0] rnd_reg();
        int r;
        r = $urandom_range(0, 8);
        return (r == 8) ? 5'd31 : 5'(r);
    endfunction

    initial begin
        Reset    = 1'b0;
        in_valid = 1'b0;
        in_we0   = 1'b0;
        in_rd0   = '0;
        in_data0 = '0;
        in_we1   = 1'b0;
        in_rd1   = '0;
        in_data1 = '0;
        chk_reg1 = '0;
        chk_reg2 = '0;
        #3;
        check("rst_regwrite", RegWrite, 0);
        check("rst_count", count, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        Reset = 1'b1;
        idle(0, 0);

        step(1, 1, 5, 64'hA5, 0, 0, 0, 5, 0);
        check("single_we", RegWrite, 1);
        check("single_reg", WriteReg, 5);
        check("single_data", WriteData, 64'hA5);
        idle(5, 0);
        check("single_drained", count, 0);

        step(1, 1, 3, 64'h10, 1, 4, 64'h20, 4, 3);
        check("dual_fwd4", fwd_data1, 64'h20);
        idle(4, 3);
        check("dual_second", WriteReg, 4);
        idle(4, 3);

        step(1, 1, 31, 64'h1, 1, 31, 64'h2, 31, 31);
        check("xzr_none", RegWrite, 0);
        idle(31, 31);

        step(1, 1, 7, 64'h1, 1, 7, 64'h2, 7, 7);
        check("same_fwd", fwd_data1, 64'h2);
        idle(7, 7);
        check("same_last", WriteData, 64'h2);
        idle(7, 7);

        for (int i = 0; i < 8; i++)
            step(1, 1, 5'(i), 64'(100 + 2 * i), 1, 5'(i + 8),
                 64'(101 + 2 * i), 5'(i), 5'(i + 8));
        in_valid = 1'b0;
        repeat (6) idle(1, 9);

        step(1, 1, 3, 64'h33, 1, 4, 64'h44, 5, 6);
        step(1, 1, 5, 64'h55, 1, 6, 64'h66, 5, 6);
        in_valid = 1'b0;
        chk_reg1 = 5;
        #2;
        Reset = 1'b0;
        #1;
        q.delete();
        check("mid_rst_we", RegWrite, 0);
        check("mid_rst_count", count, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_fwd", fwd_hit1, 0);
        @(negedge clk);
        Reset = 1'b1;
        repeat (3) idle(5, 6);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 3) != 0, 1'($urandom), rnd_reg(),
                 {$urandom, $urandom}, 1'($urandom), rnd_reg(),
                 {$urandom, $urandom}, rnd_reg(), rnd_reg());
        in_valid = 1'b0;
        repeat (6) idle(2, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end
endmodule
